// File: rtl/truth_table_sweep.sv
// Truth-table sweep engine: walks every input row of an N-input function,
// holds each row HOLD cycles, strobes the sampled point, and accumulates
// the captured truth table and its ones count for comparison against a
// golden table latched at sweep start.
module truth_table_sweep #(
   parameter int unsigned N    = 3,
   parameter int unsigned HOLD = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [(1<<N)-1:0]   mask,
   // Golden truth table; 'expect' is a reserved word, hence 'expected'.
   input  logic [(1<<N)-1:0]   expected,
   output logic [N-1:0]        row,
   output logic                s,
   output logic                valid,
   output logic                busy,
   output logic                done,
   output logic [N:0]          ones,
   output logic [(1<<N)-1:0]   result,
   output logic                mismatch
);

   localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [7:0]          hold_cnt;
   logic [(1<<N)-1:0]   mask_q;
   logic [(1<<N)-1:0]   expect_q;

   // Function value of the current row, from the latched table only.
   assign s = mask_q[row];

   // Self-check result is only meaningful once the sweep has finished.
   assign mismatch = !busy && (result != expect_q);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and per-state strobes.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      valid     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (hold_cnt == HOLD_LAST) begin
               valid = 1'b1;
               if (row == '1) begin
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Sweep datapath: latch tables on launch, advance rows, accumulate results.
   // The row counter is exactly N bits, so stepping past the last row wraps it
   // to 0 on the same edge that enters DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row      <= '0;
         hold_cnt <= '0;
         mask_q   <= '0;
         expect_q <= '0;
         ones     <= '0;
         result   <= '0;
      end else if (state == IDLE && start) begin
         mask_q   <= mask;
         expect_q <= expected;
         row      <= '0;
         hold_cnt <= '0;
         ones     <= '0;
         result   <= '0;
      end else if (state == RUN) begin
         if (valid) begin
            result[row] <= s;
            ones        <= ones + {{N{1'b0}}, s};
            row         <= row + 1'b1;
            hold_cnt    <= '0;
         end else begin
            hold_cnt <= hold_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_truth_table_sweep.sv
// Scoreboard bench for truth_table_sweep: three instances cover the default
// configuration, a multi-cycle hold, and the single-input case. Stimulus
// pushes the expected strobes; a negedge monitor pops and compares them.
module tb_truth_table_sweep;

   typedef struct {
      int id;
      int row;
      int s;
      int cyc;
   } vexp_t;

   typedef struct {
      int id;
      int ones;
      int result;
      int mm;
      int cyc;
   } dexp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   checks = 0;
   int   errors = 0;
   int   done_cnt0 = 0;

   vexp_t vq[$];
   dexp_t dq[$];

   // N=3, HOLD=1
   logic       start0 = 1'b0;
   logic [7:0] mask0 = '0, exp0 = '0;
   logic [2:0] row0;
   logic       s0, valid0, busy0, done0, mm0;
   logic [3:0] ones0;
   logic [7:0] res0;

   // N=2, HOLD=3
   logic       start1 = 1'b0;
   logic [3:0] mask1 = '0, exp1 = '0;
   logic [1:0] row1;
   logic       s1, valid1, busy1, done1, mm1;
   logic [2:0] ones1;
   logic [3:0] res1;

   // N=1, HOLD=1
   logic       start2 = 1'b0;
   logic [1:0] mask2 = '0, exp2 = '0;
   logic [0:0] row2;
   logic       s2, valid2, busy2, done2, mm2;
   logic [1:0] ones2;
   logic [1:0] res2;

   truth_table_sweep #(.N(3), .HOLD(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .mask(mask0), .expected(exp0),
      .row(row0), .s(s0), .valid(valid0), .busy(busy0), .done(done0),
      .ones(ones0), .result(res0), .mismatch(mm0));

   truth_table_sweep #(.N(2), .HOLD(3)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .mask(mask1), .expected(exp1),
      .row(row1), .s(s1), .valid(valid1), .busy(busy1), .done(done1),
      .ones(ones1), .result(res1), .mismatch(mm1));

   truth_table_sweep #(.N(1), .HOLD(1)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .mask(mask2), .expected(exp2),
      .row(row2), .s(s2), .valid(valid2), .busy(busy2), .done(done2),
      .ones(ones2), .result(res2), .mismatch(mm2));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h) t=%0t",
                  name, act, act, want, want, $time);
      end
   endtask

   task automatic on_valid(input int id, input int r, input int sv);
      vexp_t x;
      if (vq.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_valid dut%0d actual row=%0d expected no strobe t=%0t",
                  id, r, $time);
      end else begin
         x = vq.pop_front();
         chk("valid_dut", id, x.id);
         chk("valid_row", r, x.row);
         chk("valid_s", sv, x.s);
         chk("valid_cycle", cyc, x.cyc);
      end
   endtask

   task automatic on_done(input int id, input int o, input int res, input int mm);
      dexp_t x;
      if (dq.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_done dut%0d actual ones=%0d expected no pulse t=%0t",
                  id, o, $time);
      end else begin
         x = dq.pop_front();
         chk("done_dut", id, x.id);
         chk("done_ones", o, x.ones);
         chk("done_result", res, x.result);
         chk("done_mismatch", mm, x.mm);
         chk("done_cycle", cyc, x.cyc);
      end
   endtask

   // Monitor: every strobe the DUTs present is matched against the queues.
   always @(negedge clk) begin
      if (valid0) on_valid(0, int'(row0), int'(s0));
      if (valid1) on_valid(1, int'(row1), int'(s1));
      if (valid2) on_valid(2, int'(row2), int'(s2));
      if (done0) begin
         done_cnt0++;
         on_done(0, int'(ones0), int'(res0), int'(mm0));
      end
      if (done1) on_done(1, int'(ones1), int'(res1), int'(mm1));
      if (done2) on_done(2, int'(ones2), int'(res2), int'(mm2));
   end

   // Issue one start pulse and push the expected strobes for the sweep.
   task automatic launch(input int id, input int nb, input int hold,
                         input int m, input int e, input int nrows,
                         input bit push_done, input int ones_x,
                         input int res_x, input int mm_x, output int base);
      vexp_t v;
      dexp_t d;
      @(negedge clk);
      case (id)
         0: begin mask0 = m[7:0]; exp0 = e[7:0]; start0 = 1'b1; end
         1: begin mask1 = m[3:0]; exp1 = e[3:0]; start1 = 1'b1; end
         default: begin mask2 = m[1:0]; exp2 = e[1:0]; start2 = 1'b1; end
      endcase
      @(posedge clk);
      #1;
      start0 = 1'b0;
      start1 = 1'b0;
      start2 = 1'b0;
      base = cyc;
      for (int r = 0; r < nrows; r++) begin
         v.id  = id;
         v.row = r;
         v.s   = (m >> r) & 1;
         v.cyc = base + r * hold + hold - 1;
         vq.push_back(v);
      end
      if (push_done) begin
         d.id     = id;
         d.ones   = ones_x;
         d.result = res_x;
         d.mm     = mm_x;
         d.cyc    = base + (1 << nb) * hold;
         dq.push_back(d);
      end
      case (id)
         0: begin chk("launch_busy0", int'(busy0), 1); chk("launch_mm0", int'(mm0), 0);
                  chk("launch_row0", int'(row0), 0); end
         1: begin chk("launch_busy1", int'(busy1), 1); chk("launch_mm1", int'(mm1), 0); end
         default: begin chk("launch_busy2", int'(busy2), 1); chk("launch_mm2", int'(mm2), 0); end
      endcase
   endtask

   // Wait (bounded) for the monitor to consume every pending expectation.
   task automatic drain();
      for (int i = 0; i < 200; i++) begin
         if (vq.size() == 0 && dq.size() == 0) break;
         @(negedge clk);
      end
      #2;
      if (vq.size() != 0 || dq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout actual pending=%0d expected 0",
                  vq.size() + dq.size());
         vq.delete();
         dq.delete();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_row", int'(row0), 0);
      chk("rst_s", int'(s0), 0);
      chk("rst_valid", int'(valid0), 0);
      chk("rst_busy", int'(busy0), 0);
      chk("rst_done", int'(done0), 0);
      chk("rst_ones", int'(ones0), 0);
      chk("rst_result", int'(res0), 0);
      chk("rst_mismatch", int'(mm0), 0);
      rst_n = 1'b1;

      // x & ~y & z with matching golden table.
      launch(0, 3, 1, 'h20, 'h20, 8, 1'b1, 1, 'h20, 0, base);
      drain();

      // Same function, golden table differs in row 0.
      launch(0, 3, 1, 'h20, 'h21, 8, 1'b1, 1, 'h20, 1, base);
      drain();
      repeat (2) @(negedge clk);
      chk("mismatch_held", int'(mm0), 1);

      // Mask/expect change and a start pulse mid-sweep are ignored.
      launch(0, 3, 1, 'h81, 'h81, 8, 1'b1, 2, 'h81, 0, base);
      repeat (3) @(negedge clk);
      mask0  = 8'hFF;
      exp0   = 8'h00;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      drain();

      // Asynchronous reset while row 4 is presented.
      launch(0, 3, 1, 'hFF, 'hFF, 5, 1'b0, 0, 0, 0, base);
      repeat (5) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_row", int'(row0), 0);
      chk("abort_s", int'(s0), 0);
      chk("abort_valid", int'(valid0), 0);
      chk("abort_busy", int'(busy0), 0);
      chk("abort_ones", int'(ones0), 0);
      chk("abort_result", int'(res0), 0);
      chk("abort_mismatch", int'(mm0), 0);
      chk("abort_pending", vq.size() + dq.size(), 0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // First sweep after reset.
      launch(0, 3, 1, 'hFF, 'hFF, 8, 1'b1, 8, 'hFF, 0, base);
      drain();

      // N=2, HOLD=3, constant-one function.
      launch(1, 2, 3, 'hF, 'hF, 4, 1'b1, 4, 'hF, 0, base);
      drain();

      // N=1, f(x) = x.
      launch(2, 1, 1, 'h2, 'h2, 2, 1'b1, 1, 'h2, 0, base);
      drain();

      repeat (3) @(negedge clk);
      chk("done_count0", done_cnt0, 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/truth_table_sweep.md
TRUTH_TABLE_SWEEP -- requirements
Module: truth_table_sweep

Interface
REQ-001 Parameter N, default 3, legal 1..6: number of function inputs; row vector width.
REQ-002 Parameter HOLD, default 1, legal 1..255: clock cycles each row is held.
REQ-003 clk  input  1  rising-edge clock; sole clock.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a full sweep; sampled only in IDLE.
REQ-006 mask  input  2^N  function truth table; bit i = f(row i).
REQ-007 expect  input  2^N  golden truth table for self-check.
REQ-008 row  output  N  current input vector; MSB = first variable (x), LSB = last (z).
REQ-009 s  output  1  function value for row: mask_q[row].
REQ-010 valid  output  1  one-cycle strobe; row and s are the sampled point.
REQ-011 busy  output  1  high in RUN.
REQ-012 done  output  1  one-cycle pulse at sweep completion.
REQ-013 ones  output  N+1  count of rows with s = 1 in the last sweep.
REQ-014 result  output  2^N  truth table captured by the last sweep.
REQ-015 mismatch  output  1  result differs from expect_q.

Function
REQ-016 FSM states: IDLE, RUN, DONE; encoding free.
- IDLE -> RUN on start = 1.
- RUN -> DONE after the valid of row 2^N-1.
- DONE -> IDLE unconditionally after one cycle.
REQ-017 On IDLE->RUN: latch mask into mask_q and expect into expect_q; clear row, hold counter, ones and result.
REQ-018 Mask and expect changes during RUN/DONE have no effect; only latched copies are used.
REQ-019 Start timing: start high at edge t gives RUN with row = 0 from cycle t+1.
REQ-020 Row hold: each row is held HOLD cycles; the hold counter counts 0..HOLD-1.
REQ-021 valid = 1 only in RUN, only when hold counter = HOLD-1.
REQ-022 On valid: result[row] <= s and ones <= ones + s; then row increments and the hold counter clears.
REQ-023 s = mask_q[row] combinationally in every state, including IDLE.
REQ-024 Row wrap: after row 2^N-1, row returns to 0 on entry to DONE; no further valid is issued.
REQ-025 Sweep timing: done asserts at cycle t+1+2^N*HOLD (N=3, HOLD=1: t+9).
- ones and result are final in the done cycle.
REQ-026 ones range is 0..2^N; width N+1 makes overflow impossible.
REQ-027 mismatch = (result != expect_q) when not busy; forced 0 while busy; held until the next start.
REQ-028 start while in RUN or DONE is ignored.
- A start still high in the first IDLE cycle after DONE launches a new sweep.
REQ-029 busy = 1 exactly in RUN; done = 1 exactly in DONE.

Reset
REQ-030 rst_n low immediately forces IDLE, independent of clk.
- Clears row, hold counter, mask_q, expect_q, result and ones to 0.
- Drives valid, busy, done and mismatch to 0.
REQ-031 Reset mid-sweep aborts without a done pulse; partial result is discarded (zeroed).
REQ-032 The first start accepted after rst_n rises follows REQ-019 exactly.

Verification
REQ-033 Default params, mask = expect = 8'h20 (s = x & ~y & z), start 1 cycle:
- rows 0..7 on consecutive cycles; s = 1 only at row 5.
- done at t+9; ones = 1; result = 8'h20; mismatch = 0.
REQ-034 Same run with expect = 8'h21: done at t+9, mismatch = 1; it clears to 0 on the first busy cycle of the next start.
REQ-035 HOLD = 3, N = 2, mask = 4'hF:
- each row held 3 cycles; valid on every 3rd cycle.
- done at t+13; ones = 4 (full-width value 3'b100).
REQ-036 Change mask to 8'hFF mid-RUN and pulse start mid-RUN: sweep uses the original mask; no restart; done count unchanged.
REQ-037 rst_n low at row 4 of an 8'hFF sweep:
- all outputs 0 asynchronously; no done.
- next start yields ones = 8.
REQ-038 N = 1, mask = 2'b10: row 0 then row 1; s = 0 then 1; done at t+3; ones = 1.
